inst_prefetch_buf: RTL and testbench

Parametrised instruction prefetch queue between the MIPS core's fetch stage and the instruction ROM. It issues sequential word fetches to a fixed-latency, pipelined ROM ahead of demand. Returned instructions are buffered with their PCs in a DEPTH-entry FIFO, and a redirect flushes queued and in-flight fetches. It replaces the direct core-to-ROM fetch connection in the minimum SOPC.

---
 rtl/inst_prefetch_buf.sv | 126 ++++++++++++
 tb/tb_inst_prefetch_buf.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_buf.sv
// Instruction prefetch queue between the fetch stage and a pipelined ROM.
// Issues sequential word fetches ahead of demand; a redirect flushes all.
module inst_prefetch_buf #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter int                MEM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o,
  output logic              mem_ce_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 3;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [MEM_LAT-1:0] vld;
  logic [ADDR_W-1:0] pc_sr [MEM_LAT];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     occ;
  logic [SW-1:0]     credit;
  logic              push;
  logic              pop_ok;

  // Queued plus in-flight entries; a request is only made if it has a slot.
  always_comb begin
    credit = SW'(occ);
    for (int i = 0; i < MEM_LAT; i++) begin
      credit = credit + SW'(vld[i]);
    end
  end

  assign mem_ce_o     = (state == RUN) && (credit < SW'(DEPTH));
  assign mem_addr_o   = fetch_pc;
  assign push         = vld[MEM_LAT-1];
  assign pop_ok       = pop_i && (occ != '0);
  assign inst_o       = data_q[rd_ptr];
  assign inst_pc_o    = pc_q[rd_ptr];
  assign inst_valid_o = (occ != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: if (fetch_en_i) state <= RUN;
        RUN:  if (!fetch_en_i) state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_i) begin
      fetch_pc <= redirect_pc_i;
    end else if (mem_ce_o) begin
      fetch_pc <= fetch_pc + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      for (int i = 0; i < MEM_LAT; i++) pc_sr[i] <= '0;
    end else begin
      vld <= redirect_i ? '0 : ((vld << 1) | MEM_LAT'(mem_ce_o));
      pc_sr[0] <= fetch_pc;
      for (int i = MEM_LAT - 1; i > 0; i--) pc_sr[i] <= pc_sr[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (redirect_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= mem_data_i;
        pc_q[wr_ptr]   <= pc_sr[MEM_LAT-1];
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop_ok})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push && !redirect_i) assert (occ < CW'(DEPTH));
  end

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// Randomised bench for inst_prefetch_buf against a queue-based model.
// ROM returns addr ^ 0xA5A5A5A5 two cycles after the request.
module tb_inst_prefetch_buf;

  localparam int L = 2;
  localparam int D = 4;
  localparam logic [31:0] K = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        pop_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        mem_ce_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_i;
  logic [31:0] rp0, rp1;

  inst_prefetch_buf #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(D), .MEM_LAT(L), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .fetch_en_i(fetch_en_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .pop_i(pop_i),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_valid_o(inst_valid_o), .mem_ce_o(mem_ce_o),
    .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rp0 <= mem_addr_o ^ K;
    rp1 <= rp0;
  end
  assign mem_data_i = rp1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    int          age;
  } fl_t;

  fl_t         infl[$];
  logic [31:0] fq[$];
  bit          m_run;
  logic [31:0] m_fpc;

  function automatic bit m_ce();
    return m_run && (fq.size() + infl.size() < D);
  endfunction

  task automatic m_reset();
    infl.delete();
    fq.delete();
    m_run = 0;
    m_fpc = 32'h0;
  endtask

  task automatic step(input bit en, input bit rd,
                      input logic [31:0] rpc, input bit pp);
    bit ce;
    fetch_en_i    = en;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    pop_i         = pp;
    ce = m_ce();
    check("ce", 32'(mem_ce_o), 32'(ce));
    check("addr", mem_addr_o, m_fpc);
    check("valid", 32'(inst_valid_o), 32'(fq.size() != 0));
    if (fq.size() != 0) begin
      check("pc", inst_pc_o, fq[0]);
      check("inst", inst_o, fq[0] ^ K);
    end
    @(posedge clk);
    if (rd) begin
      fq.delete();
      infl.delete();
      m_fpc = rpc;
    end else begin
      if (pp && fq.size() != 0) void'(fq.pop_front());
      if (infl.size() != 0 && infl[0].age == L) begin
        fq.push_back(infl[0].pc);
        void'(infl.pop_front());
      end
      foreach (infl[i]) infl[i].age++;
      if (ce) begin
        infl.push_back('{pc: m_fpc, age: 1});
        m_fpc = m_fpc + 32'd4;
      end
    end
    m_run = en;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals();
    check("rst_ce", 32'(mem_ce_o), 32'd0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_inst", inst_o, 32'h0);
    check("rst_pc", inst_pc_o, 32'h0);
  endtask

  initial begin
    int n;
    int k;
    rst = 1'b0;
    fetch_en_i = 0;
    redirect_i = 0;
    redirect_pc_i = '0;
    pop_i = 0;
    m_reset();
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b1;

    // startup and streaming: pop every cycle
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (inst_valid_o) n++;
      step(1, 0, 0, 1);
    end
    check("stream_valid", 32'(n), 32'd64);

    // backpressure after a flush: exactly DEPTH requests
    step(1, 1, 32'h200, 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (mem_ce_o) n++;
      step(1, 0, 0, 0);
    end
    check("bp_reqs", 32'(n), 32'(D));
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);

    // redirect with pop in the same cycle
    step(1, 1, 32'h100, 1);
    k = 1;
    while (!inst_valid_o && k < 10) begin
      step(1, 0, 0, 0);
      k++;
    end
    check("redir_lat", 32'(k), 32'(L + 2));
    check("redir_pc", inst_pc_o, 32'h100);

    // address wrap, then pops on an empty queue
    step(1, 1, 32'hFFFFFFFC, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1);
    step(0, 1, 32'h40, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 9) == 0) r = 32'hFFFFFFF8;
      step($urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0,
           {r[31:2], 2'b00}, $urandom_range(0, 3) != 0);
    end

    // asynchronous reset between edges
    fetch_en_i = 1;
    pop_i = 0;
    redirect_i = 0;
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals();
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) step(1, 0, 0, $urandom_range(0, 1) == 1);
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 5) != 0, $urandom_range(0, 24) == 0,
           {$urandom_range(0, 32'h3FFF), 2'b00}, $urandom_range(0, 2) != 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
